// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell steps through WIDTH bits, one per clock.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output (ovf).
module fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic ca_o
);
    assign s_o  = a_i ^ b_i ^ c_i;
    assign ca_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_ADD_OVF_EN
   ,output logic             ovf
`endif
);
    localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sr_q, sr_d;
    logic             cr_q, cr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_ca;
    logic [WIDTH:0]   sr_ext;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    fa u_fa (
        .a_i  (sa_q[0]),
        .b_i  (sb_q[0]),
        .c_i  (cr_q),
        .s_o  (fa_s),
        .ca_o (fa_ca)
    );

    // New sum bit enters at the MSB; the slice form also covers WIDTH=1.
    assign sr_ext = {fa_s, sr_q};

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        cr_d    = cr_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sa_d    = a;
                    sb_d    = b;
                    cr_d    = cin;
                    cnt_d   = '0;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sr_d  = sr_ext[WIDTH:1];
                cr_d  = fa_ca;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
`ifdef SERIAL_ADD_OVF_EN
                    // Carry into the MSB differs from carry out of it.
                    ovf_d   = cr_q ^ fa_ca;
`endif
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            cr_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            cr_q    <= cr_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign sum       = sr_q;
    assign cout      = cr_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized bench for serial_add_ctrl (WIDTH=8 and WIDTH=1 instances) against
// an arithmetic reference model.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         iv8, ir8, ov8, or8, cin8, cout8, busy8;
    logic [W-1:0] a8, b8, sum8;
    logic         iv1, ir1, ov1, or1, cin1, cout1, busy1;
    logic [0:0]   a1, b1, sum1;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf8, ovf1;
`endif

    int checks = 0;
    int failures = 0;

    serial_add_ctrl #(.WIDTH(W)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(cin8), .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(cout8),
        .busy(busy8)
`ifdef SERIAL_ADD_OVF_EN
       ,.ovf(ovf8)
`endif
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .cin(cin1), .out_valid(ov1), .out_ready(or1), .sum(sum1), .cout(cout1),
        .busy(busy1)
`ifdef SERIAL_ADD_OVF_EN
       ,.ovf(ovf1)
`endif
    );

    function automatic logic [W:0] ref_add(logic [W-1:0] x, logic [W-1:0] y, logic c);
        int unsigned s;
        s = int'(x) + int'(y) + int'(c);
        return s[W:0];
    endfunction

    function automatic logic ref_ovf(logic [W-1:0] x, logic [W-1:0] y, logic c);
        int s;
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        return (s > 127) || (s < -128);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One transaction on the WIDTH=8 instance, with bp cycles of backpressure.
    task automatic op8(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input int bp);
        logic [W:0] e;
        int lat;
        e = ref_add(x, y, c);
        checks++;
        if (ir8 !== 1'b1) begin failures++; $display("FAIL op_idle_ready act=%b exp=1", ir8); end
        a8 = x; b8 = y; cin8 = c; iv8 = 1'b1; or8 = (bp == 0);
        tick();
        iv8 = 1'b0;
        lat = 0;
        while (ov8 !== 1'b1 && lat < 200) begin
            checks++;
            if (ir8 !== 1'b0 || busy8 !== 1'b1) begin
                failures++; $display("FAIL run_flags in_ready=%b busy=%b exp 0/1", ir8, busy8);
            end
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); iv8 = 1'($urandom);
            tick();
            lat++;
        end
        iv8 = 1'b0;
        checks++;
        if (lat != W) begin failures++; $display("FAIL latency act=%0d exp=%0d", lat, W); end
        checks++;
        if ({cout8, sum8} !== e) begin
            failures++; $display("FAIL sum %h+%h+%b act=%b_%h exp=%b_%h", x, y, c, cout8, sum8, e[W], e[W-1:0]);
        end
`ifdef SERIAL_ADD_OVF_EN
        checks++;
        if (ovf8 !== ref_ovf(x, y, c)) begin
            failures++; $display("FAIL ovf %h+%h+%b act=%b exp=%b", x, y, c, ovf8, ref_ovf(x, y, c));
        end
`endif
        for (int i = 0; i < bp; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); iv8 = 1'($urandom);
            tick();
            checks++;
            if ({ov8, ir8, cout8, sum8} !== {1'b1, 1'b0, e}) begin
                failures++; $display("FAIL bp_hold ov=%b ir=%b act=%b_%h exp=%b_%h", ov8, ir8, cout8, sum8, e[W], e[W-1:0]);
            end
        end
        iv8 = 1'b0; or8 = 1'b1;
        tick();
        checks++;
        if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
            failures++; $display("FAIL handoff out_valid=%b in_ready=%b exp 0/1", ov8, ir8);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; iv8 = 1'b1; iv1 = 1'b1;
        #1;
        checks++;
        if ({ir8, ov8, busy8, cout8, sum8} !== {3'b100, 1'b0, 8'h00}) begin
            failures++; $display("FAIL reset_async ir=%b ov=%b busy=%b sum=%h cout=%b", ir8, ov8, busy8, sum8, cout8);
        end
`ifdef SERIAL_ADD_OVF_EN
        checks++;
        if (ovf8 !== 1'b0) begin failures++; $display("FAIL reset_ovf act=%b exp=0", ovf8); end
`endif
        tick(); tick();
        checks++;
        if (busy8 !== 1'b0 || busy1 !== 1'b0) begin
            failures++; $display("FAIL reset_beats_valid busy8=%b busy1=%b exp 0", busy8, busy1);
        end
        iv8 = 1'b0; iv1 = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        op8(8'h5A, 8'h3C, 1'b0, 0);
        op8(8'hFF, 8'h01, 1'b0, 0);
        op8(8'hFF, 8'hFF, 1'b1, 0);
        op8(8'h7F, 8'h01, 1'b0, 0);
        op8(8'h80, 8'h80, 1'b0, 0);
        op8(8'h40, 8'h20, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        op8(8'($urandom), 8'($urandom), 1'($urandom), 5);
        op8(8'h12, 8'h34, 1'b1, 1);
    endtask

    task automatic test_reset_mid_run();
        a8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b1; iv8 = 1'b1; or8 = 1'b1;
        tick();
        iv8 = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({ir8, ov8, busy8, cout8, sum8} !== {3'b100, 1'b0, 8'h00}) begin
            failures++; $display("FAIL reset_mid_run ir=%b ov=%b busy=%b sum=%h cout=%b", ir8, ov8, busy8, sum8, cout8);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        op8(8'h10, 8'h01, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x, y;
        logic [W:0] e;
        int k;
        x = 8'($urandom); y = 8'($urandom);
        e = ref_add(x, y, 1'b0);
        a8 = x; b8 = y; cin8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
        k = 0;
        do begin tick(); k++; end while (ov8 !== 1'b1 && k < 50);
        checks++;
        if ({cout8, sum8} !== e) begin failures++; $display("FAIL b2b_first act=%h exp=%h", {cout8, sum8}, e); end
        k = 0;
        do begin tick(); k++; end while (ov8 !== 1'b1 && k < 50);
        checks++;
        if (k != W + 2) begin failures++; $display("FAIL b2b_interval act=%0d exp=%0d", k, W + 2); end
        checks++;
        if ({cout8, sum8} !== e) begin failures++; $display("FAIL b2b_second act=%h exp=%h", {cout8, sum8}, e); end
        iv8 = 1'b0;
        tick();
    endtask

    task automatic test_width1();
        logic [1:0] e;
        int lat;
        for (int i = 0; i < 8; i++) begin
            a1 = 1'(i); b1 = 1'(i >> 1); cin1 = 1'(i >> 2);
            e = 2'(int'(a1) + int'(b1) + int'(cin1));
            checks++;
            if (ir1 !== 1'b1) begin failures++; $display("FAIL w1_ready act=%b exp=1", ir1); end
            iv1 = 1'b1; or1 = 1'b1;
            tick();
            iv1 = 1'b0;
            lat = 0;
            while (ov1 !== 1'b1 && lat < 20) begin tick(); lat++; end
            checks++;
            if (lat != 1) begin failures++; $display("FAIL w1_latency act=%0d exp=1", lat); end
            checks++;
            if ({cout1, sum1} !== e) begin failures++; $display("FAIL w1_sum case=%0d act=%b exp=%b", i, {cout1, sum1}, e); end
`ifdef SERIAL_ADD_OVF_EN
            checks++;
            if (ovf1 !== (cin1 ^ e[1])) begin failures++; $display("FAIL w1_ovf act=%b exp=%b", ovf1, cin1 ^ e[1]); end
`endif
            tick();
        end
        a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0; iv1 = 1'b1; or1 = 1'b1;
        lat = 0;
        do begin tick(); lat++; end while (ov1 !== 1'b1 && lat < 20);
        lat = 0;
        do begin tick(); lat++; end while (ov1 !== 1'b1 && lat < 20);
        checks++;
        if (lat != 3) begin failures++; $display("FAIL w1_interval act=%0d exp=3", lat); end
        iv1 = 1'b0;
        tick();
    endtask

    task automatic test_random();
        repeat (40) op8(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3));
    endtask

    initial begin
        iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0;
        iv1 = 1'b0; or1 = 1'b1; a1 = '0; b1 = '0; cin1 = 1'b0;
        rst = 1'b1;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_width1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder sequencer that computes a WIDTH-bit sum with one `fa` full-adder cell, one bit per clock, instead of a parallel ripple or carry-select array. It holds the operands in shift registers and the carry in a flip-flop, and steps the FSM through the bits. A valid/ready handshake on each side connects it to area-constrained datapaths where an add result is needed every WIDTH+2 cycles.

## Interface
Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 1 to 64.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  high only in IDLE.
- a  input  WIDTH  operand A; sampled on acceptance.
- b  input  WIDTH  operand B; sampled on acceptance.
- cin  input  1  carry-in; sampled on acceptance.
- out_valid  output  1  high only in DONE.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result; stable while out_valid is high.
- cout  output  1  carry out of bit WIDTH-1.
- busy  output  1  high in RUN or DONE.
- ovf  output  1  signed overflow; present only with SERIAL_ADD_OVF_EN.

## Operation
- FSM states are IDLE, RUN and DONE. Use a one-hot or binary encoding.
- Internal state: shift registers sa and sb (WIDTH bits each), result register sr (WIDTH bits), carry flip-flop cr, and bit counter cnt (width $clog2(WIDTH+1), minimum 1).

IDLE:
- in_ready = 1.
- On the edge where in_valid && in_ready: sa<=a, sb<=b, cr<=cin, cnt<=0, go to RUN.

RUN, one bit per cycle:
- The `fa` cell is driven with a=sa[0], b=sb[0], c=cr.
- sr <= {s, sr[WIDTH-1:1]}, so each new bit enters at the MSB and the register shifts right.
- sa and sb shift right, filling with 0.
- cr <= ca.
- cnt <= cnt+1.
- When cnt==WIDTH-1 at the edge, go to DONE. After that edge sr holds the full sum and cr holds cout.

DONE:
- out_valid = 1.
- sum = sr and cout = cr. Both are held unchanged until the edge where out_valid && out_ready; then go to IDLE.
- A new request is never accepted in the same cycle as the result handoff.

Handshake rules:
- in_valid while busy is ignored. The operands are not captured and the request has no side effects.
- a, b and cin may change freely after acceptance.
- out_ready may be held high permanently. Result handoff then happens on the first DONE cycle.

Arithmetic:
- {cout, sum} = a + b + cin, computed modulo 2^(WIDTH+1).
- cnt never exceeds WIDTH-1 in RUN.

Boundary cases:
- WIDTH=1: RUN lasts exactly one cycle.
- Reset asserted mid-RUN or mid-DONE: the operation is abandoned immediately and no partial result is output.
- in_valid and rst asserted together: rst wins.

## Timing
Reset values (asynchronous, take effect immediately on rst):
- FSM = IDLE.
- in_ready = 1, out_valid = 0, busy = 0.
- sum = 0, cout = 0, ovf = 0.
- sa, sb, sr, cr and cnt all cleared to 0.

Cycle-level behaviour:
- Acceptance happens at edge E0. RUN occupies edges E1..EWIDTH.
- out_valid is high after edge EWIDTH, so latency from acceptance to out_valid is WIDTH cycles.
- With out_ready held at 1, the handoff happens at E(WIDTH+1) and the next acceptance is possible at E(WIDTH+2). Minimum issue interval is WIDTH+2 cycles.
- Backpressure stretches DONE by one cycle for each cycle that out_ready is low, with no limit.
- All outputs come directly from registers or the FSM state. There are no combinational paths from input to output.

## Configuration
- Macro: SERIAL_ADD_OVF_EN.

When defined:
- The ovf port exists.
- On the last RUN edge (cnt==WIDTH-1), the FSM captures ovf <= cr ^ ca, i.e. the carry into the MSB XOR the carry out of the MSB.
- ovf is held through DONE.
- ovf is cleared on reset and on acceptance.
- For WIDTH=1, ovf = cin ^ cout.

When undefined:
- The ovf port and its flip-flop are absent.
- All other behaviour is identical.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0, out_ready=1 -> out_valid rises 8 cycles after acceptance with sum=0x96, cout=0; one cycle later in_ready=1.
- WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure: after out_valid rises, out_ready is held at 0 for 5 cycles while a, b and in_valid toggle -> sum, cout and out_valid stay stable and in_ready stays 0. Handoff occurs on the first cycle with out_ready=1.
- Reset during RUN at cnt=3 -> all outputs go to their reset values immediately. A new request 0x10+0x01 issued after reset returns 0x11 with no trace of the abandoned operation.
- With SERIAL_ADD_OVF_EN, WIDTH=8: 0x7F+0x01 -> ovf=1; 0x80+0x80 -> ovf=1, cout=1, sum=0x00; 0x40+0x20 -> ovf=0.
- WIDTH=1: a=1, b=1, cin=1 -> out_valid after 1 cycle with sum=1, cout=1; minimum issue interval of 3 cycles confirmed.
